// File: rtl/serial_cmd_deser_pkg.sv
// Shared definitions for the serial settings bus slave: FSM states, frame geometry, counter helper.
// Latency: none (types and constants only).
// Backpressure: none.
package serial_cmd_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam int HDR_BITS   = 8;
    localparam int DATA_BITS  = 32;
    localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
    localparam int RD_BIT     = 7;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    // bit counter saturates so over-long frames can never wrap back to a valid length
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/serial_cmd_deser_sync_edge_det.sv
// Synchroniser chain plus delay flop giving level and single-cycle rise/fall pulses.
// Latency: STAGES master_clk cycles to level, pulses valid in the same cycle as the new level.
// Backpressure: none; the input is free-running.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic master_clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/serial_cmd_deser.sv
// Serial settings bus slave: 40-bit write frames to addr/data/strobe, read frames shift out a status word.
// Latency: strobe 3 master_clk edges after serial_enable is first sampled low; optional SERIAL_FRAME_CHECK_EN adds frame_err_cnt.
// Backpressure: none; the bus master is never stalled, malformed frames are dropped.
module serial_cmd_deser
    import serial_cmd_deser_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RB      = 4
) (
    input  logic        master_clk,
    input  logic        reset_n,
    input  logic        serial_clock,
    input  logic        serial_enable,
    input  logic        serial_sdi,
    output logic        serial_sdo,
    output logic        serial_sdo_oe,
    input  logic [31:0] readback_0,
    input  logic [31:0] readback_1,
    input  logic [31:0] readback_2,
    input  logic [31:0] readback_3,
    output logic [6:0]  serial_addr,
    output logic [31:0] serial_data,
    output logic        serial_strobe
`ifdef SERIAL_FRAME_CHECK_EN
    ,
    output logic [7:0]  frame_err_cnt
`endif
);

    localparam logic [7:0] NUM_RB_L = 8'(NUM_RB);

    logic clk_rise, clk_fall, clk_level_unused;
    logic en_level, en_rise, en_fall;
    logic sdi_level, sdi_rise_unused, sdi_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .din        (serial_clock),
        .level      (clk_level_unused),
        .rise       (clk_rise),
        .fall       (clk_fall)
    );

    // enable resets high so a frame already running at reset release cannot look like a fresh start
    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .din        (serial_enable),
        .level      (en_level),
        .rise       (en_rise),
        .fall       (en_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .master_clk (master_clk),
        .reset_n    (reset_n),
        .din        (serial_sdi),
        .level      (sdi_level),
        .rise       (sdi_rise_unused),
        .fall       (sdi_fall_unused)
    );

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_n;
    logic [HDR_BITS-1:0]    hdr_q, hdr_n, hdr_shift;
    logic [DATA_BITS-1:0]   wdat_q, wdat_n;
    logic [DATA_BITS-1:0]   shift_q, shift_n;
    logic [DATA_BITS-1:0]   rb_word;
    logic [6:0]             addr_q, addr_n;
    logic [DATA_BITS-1:0]   data_q, data_n;
    logic                   arm_q, strobe_q, strobe_n, oe_q, err_inc;

    assign hdr_shift = {hdr_q[HDR_BITS-2:0], sdi_level};

    always_comb begin
        rb_word = '0;
        case (hdr_shift[6:0])
            7'd0:    rb_word = readback_0;
            7'd1:    rb_word = readback_1;
            7'd2:    rb_word = readback_2;
            7'd3:    rb_word = readback_3;
            default: rb_word = '0;
        endcase
        if ({1'b0, hdr_shift[6:0]} >= NUM_RB_L) begin
            rb_word = '0;
        end
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            wdat_q    <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            arm_q     <= 1'b0;
            strobe_q  <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            hdr_q     <= hdr_n;
            wdat_q    <= wdat_n;
            shift_q   <= shift_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            arm_q     <= arm_q | ~en_level;
            strobe_q  <= strobe_n;
            oe_q      <= (state_n == ST_RDATA);
        end
    end

    // a clock edge is folded into the *_n values before an enable fall in the same cycle inspects them
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        hdr_n     = hdr_q;
        wdat_n    = wdat_q;
        shift_n   = shift_q;
        addr_n    = addr_q;
        data_n    = data_q;
        strobe_n  = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_rise && arm_q) begin
                    state_n   = ST_HDR;
                    bit_cnt_n = '0;
                end
            end
            ST_HDR: begin
                if (clk_rise) begin
                    hdr_n     = hdr_shift;
                    bit_cnt_n = cnt_inc(bit_cnt_q);
                    if (bit_cnt_q == HDR_LAST) begin
                        if (hdr_shift[RD_BIT]) begin
                            state_n = ST_RDATA;
                            shift_n = rb_word;
                        end else begin
                            state_n = ST_WDATA;
                        end
                    end
                end
                if (en_fall) begin
                    state_n = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (clk_rise) begin
                    if (bit_cnt_q < FRAME_CNT) begin
                        wdat_n = {wdat_q[DATA_BITS-2:0], sdi_level};
                    end
                    bit_cnt_n = cnt_inc(bit_cnt_q);
                end
                if (en_fall) begin
                    state_n = ST_IDLE;
                    if (bit_cnt_n == FRAME_CNT) begin
                        addr_n   = hdr_q[6:0];
                        data_n   = wdat_n;
                        strobe_n = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                if (clk_rise) begin
                    bit_cnt_n = cnt_inc(bit_cnt_q);
                end
                if (clk_fall) begin
                    shift_n = {shift_q[DATA_BITS-2:0], 1'b0};
                end
                if (en_fall) begin
                    state_n = ST_IDLE;
                    err_inc = (bit_cnt_n != FRAME_CNT);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign serial_addr   = addr_q;
    assign serial_data   = data_q;
    assign serial_strobe = strobe_q;
    assign serial_sdo_oe = oe_q;
    assign serial_sdo    = oe_q & shift_q[DATA_BITS-1];

`ifdef SERIAL_FRAME_CHECK_EN
    logic [7:0] err_q;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign frame_err_cnt = err_q;
`else
    logic err_inc_unused;
    assign err_inc_unused = err_inc;
`endif

endmodule

// File: tb/tb_serial_cmd_deser.sv
// Bench for serial_cmd_deser: drives framed serial traffic and checks settings bus and readback output.
module tb_serial_cmd_deser;

    localparam int HALF = 5;

    logic        master_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_clock = 1'b0;
    logic        serial_enable = 1'b0;
    logic        serial_sdi = 1'b0;
    logic        serial_sdo, serial_sdo_oe;
    logic [31:0] readback_0 = 32'hA0A0A0A0;
    logic [31:0] readback_1 = 32'hB1B1B1B1;
    logic [31:0] readback_2 = 32'h0;
    logic [31:0] readback_3 = 32'hC3C3C3C3;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
`ifdef SERIAL_FRAME_CHECK_EN
    logic [7:0]  frame_err_cnt;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    logic [4:1]  stb_pat;
    logic [6:0]  stb_addr;
    logic [31:0] stb_data;
    logic [31:0] rd_word;
    logic        rd_tail, oe_pre, oe_mid, oe_post;

    always #5 master_clk = ~master_clk;

    serial_cmd_deser dut (
        .master_clk    (master_clk),
        .reset_n       (reset_n),
        .serial_clock  (serial_clock),
        .serial_enable (serial_enable),
        .serial_sdi    (serial_sdi),
        .serial_sdo    (serial_sdo),
        .serial_sdo_oe (serial_sdo_oe),
        .readback_0    (readback_0),
        .readback_1    (readback_1),
        .readback_2    (readback_2),
        .readback_3    (readback_3),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe)
`ifdef SERIAL_FRAME_CHECK_EN
        ,
        .frame_err_cnt (frame_err_cnt)
`endif
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    // drives one frame of nbits (optionally pulsing reset at bit rst_at), then records strobe for 4 cycles
    task automatic drive_frame(input logic [7:0] hdr, input logic [31:0] data, input int nbits, input int rst_at);
        logic [47:0] vec;
        vec = {hdr, data, 8'h00};
        oe_pre = 1'b0; oe_mid = 1'b1; rd_word = '0; rd_tail = 1'b0;
        stb_pat = '0; stb_addr = '0; stb_data = '0;
        serial_enable = 1'b1;
        serial_clock = 1'b0;
        cycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset_n = 1'b0;
                cycles(3);
                reset_n = 1'b1;
            end
            serial_clock = 1'b0;
            serial_sdi = vec[47-i];
            cycles(HALF);
            serial_clock = 1'b1;
            cycles(HALF);
            if (i == 5) oe_pre = serial_sdo_oe;
            if (i >= 7 && i <= 38) begin
                rd_word[38-i] = serial_sdo;
                oe_mid = oe_mid & serial_sdo_oe;
            end
            if (i == 39) rd_tail = serial_sdo;
        end
        serial_clock = 1'b0;
        serial_sdi = 1'b0;
        cycles(HALF);
        serial_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge master_clk);
            stb_pat[k] = serial_strobe;
            if (k == 3) begin
                stb_addr = serial_addr;
                stb_data = serial_data;
            end
        end
        oe_post = serial_sdo_oe;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycles(3);
        total++; if (serial_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", serial_strobe); end
        total++; if (serial_addr !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", serial_addr); end
        total++; if (serial_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", serial_data); end
        total++; if ({serial_sdo, serial_sdo_oe} !== 2'b00) begin bad++; $display("FAIL reset_sdo got=%b want=00", {serial_sdo, serial_sdo_oe}); end
`ifdef SERIAL_FRAME_CHECK_EN
        total++; if (frame_err_cnt !== 8'h00) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", frame_err_cnt); end
`endif
        reset_n = 1'b1;
        cycles(6);
    endtask

    task automatic test_write();
        wr_t w;
        exp_wr_q.push_back('{addr: 7'h14, data: 32'hDEADBEEF});
        drive_frame(8'h14, 32'hDEADBEEF, 40, -1);
        w = exp_wr_q.pop_front();
        total++; if (stb_pat !== 4'b0100) begin bad++; $display("FAIL write_strobe_timing got=%b want=0100", stb_pat); end
        total++; if (stb_addr !== w.addr) begin bad++; $display("FAIL write_addr got=%h want=%h", stb_addr, w.addr); end
        total++; if (stb_data !== w.data) begin bad++; $display("FAIL write_data got=%h want=%h", stb_data, w.data); end
        cycles(4);
        total++; if (serial_data !== 32'hDEADBEEF) begin bad++; $display("FAIL write_hold got=%h want=deadbeef", serial_data); end
    endtask

    task automatic test_read(input logic [7:0] hdr, input logic [31:0] expect_word, input string tag);
        logic [31:0] e;
        exp_rd_q.push_back(expect_word);
        drive_frame(hdr, 32'h0, 40, -1);
        e = exp_rd_q.pop_front();
        total++; if (rd_word !== e) begin bad++; $display("FAIL %s_sdo_word got=%h want=%h", tag, rd_word, e); end
        total++; if (rd_tail !== 1'b0) begin bad++; $display("FAIL %s_sdo_tail got=%b want=0", tag, rd_tail); end
        total++; if ({oe_pre, oe_mid, oe_post} !== 3'b010) begin bad++; $display("FAIL %s_oe got=%b want=010", tag, {oe_pre, oe_mid, oe_post}); end
        total++; if (stb_pat !== 4'b0000) begin bad++; $display("FAIL %s_no_strobe got=%b want=0000", tag, stb_pat); end
    endtask

    task automatic test_bad_frames();
        logic [7:0] err0;
`ifdef SERIAL_FRAME_CHECK_EN
        err0 = frame_err_cnt;
`else
        err0 = 8'h00;
`endif
        drive_frame(8'h20, 32'h11111111, 39, -1);
        total++; if (stb_pat !== 4'b0000) begin bad++; $display("FAIL short_frame_strobe got=%b want=0000", stb_pat); end
        drive_frame(8'h21, 32'h22222222, 41, -1);
        total++; if (stb_pat !== 4'b0000) begin bad++; $display("FAIL long_frame_strobe got=%b want=0000", stb_pat); end
        total++; if ({serial_addr, serial_data} !== {7'h14, 32'hDEADBEEF}) begin bad++; $display("FAIL bad_frame_hold got=%h/%h want=14/deadbeef", serial_addr, serial_data); end
`ifdef SERIAL_FRAME_CHECK_EN
        total++; if (frame_err_cnt !== err0 + 8'd2) begin bad++; $display("FAIL errcnt got=%0d want=%0d", frame_err_cnt, err0 + 8'd2); end
`else
        err0 = err0 + 8'd0;
`endif
    endtask

    task automatic test_reset_mid_frame();
        wr_t w;
        drive_frame(8'h33, 32'hCAFEF00D, 40, 20);
        total++; if (stb_pat !== 4'b0000) begin bad++; $display("FAIL midreset_strobe got=%b want=0000", stb_pat); end
        total++; if ({serial_addr, serial_data} !== 39'h0) begin bad++; $display("FAIL midreset_outputs got=%h/%h want=0/0", serial_addr, serial_data); end
        exp_wr_q.push_back('{addr: 7'h33, data: 32'hCAFEF00D});
        drive_frame(8'h33, 32'hCAFEF00D, 40, -1);
        w = exp_wr_q.pop_front();
        total++; if (stb_pat !== 4'b0100) begin bad++; $display("FAIL after_reset_strobe got=%b want=0100", stb_pat); end
        total++; if ({stb_addr, stb_data} !== {w.addr, w.data}) begin bad++; $display("FAIL after_reset_write got=%h/%h want=%h/%h", stb_addr, stb_data, w.addr, w.data); end
    endtask

    task automatic test_back_to_back();
        wr_t w;
        logic [7:0]  hdrs [2];
        logic [31:0] dats [2];
        hdrs[0] = 8'h11; dats[0] = 32'h01234567;
        hdrs[1] = 8'h7F; dats[1] = 32'h89ABCDEF;
        for (int f = 0; f < 2; f++) begin
            exp_wr_q.push_back('{addr: hdrs[f][6:0], data: dats[f]});
            drive_frame(hdrs[f], dats[f], 40, -1);
            w = exp_wr_q.pop_front();
            total++; if (stb_pat !== 4'b0100) begin bad++; $display("FAIL b2b%0d_strobe got=%b want=0100", f, stb_pat); end
            total++; if ({stb_addr, stb_data} !== {w.addr, w.data}) begin bad++; $display("FAIL b2b%0d_write got=%h/%h want=%h/%h", f, stb_addr, stb_data, w.addr, w.data); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_write();
        readback_2 = 32'h12345678;
        test_read(8'h82, 32'h12345678, "read2");
        test_bad_frames();
        test_reset_mid_frame();
        test_read(8'h85, 32'h00000000, "read_oob");
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
